// File: rtl/stack_game_ctrl_pkg.sv
// Shared constants for the stacker game sequencer: default geometry,
// the level-0 pattern and the FSM state encoding.
package stack_game_ctrl_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_ROWS      = 8;
    localparam int DEF_START_LEN = 3;

    localparam logic [DEF_WIDTH-1:0] DEF_START_PATTERN = 8'b1110_0000;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_COMMIT = 3'd4;
    localparam logic [2:0] ST_LOSE   = 3'd5;
    localparam logic [2:0] ST_WIN    = 3'd6;

    // A column is lit in the level-0 pattern when it lies in the top len bits.
    function automatic logic startBit(input int col, input int width, input int len);
        return col >= (width - len);
    endfunction

endpackage

// File: rtl/stack_game_ctrl_row_mem.sv
// Stacked-row storage: one register per row, synchronous write and clear,
// two combinational read ports (display and row-below lookup).
module stack_row_mem #(
    parameter int WIDTH = 8,
    parameter int ROWS  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    wrEn,
    input  logic [$clog2(ROWS)-1:0] wrAddr,
    input  logic [WIDTH-1:0]        wrData,
    input  logic [$clog2(ROWS)-1:0] rdAddrA,
    output logic [WIDTH-1:0]        rdDataA,
    input  logic [$clog2(ROWS)-1:0] rdAddrB,
    output logic [WIDTH-1:0]        rdDataB
);
    localparam int AW = $clog2(ROWS);

    logic [WIDTH-1:0] rowsReg [ROWS];

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : gRow
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    rowsReg[gi] <= '0;
                end else if (wrEn && (wrAddr == AW'(gi))) begin
                    rowsReg[gi] <= wrData;
                end
            end
        end
    endgenerate

    assign rdDataA = rowsReg[rdAddrA];
    assign rdDataB = rowsReg[rdAddrB];

endmodule

// File: rtl/stack_game_ctrl.sv
// Stacker game sequencer: loads row patterns into the shifter, captures the
// stop position, overlaps it with the row below and tracks level, win and loss.
module stack_game_ctrl
    import stack_game_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ROWS      = DEF_ROWS,
    parameter int START_LEN = DEF_START_LEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       startBtn,
    input  logic                       stopBtn,
    input  logic [WIDTH-1:0]           curRow,
    output logic                       shiftLoad,
    output logic [WIDTH-1:0]           shiftPattern,
    output logic                       shiftRun,
    input  logic [$clog2(ROWS)-1:0]    rowSel,
    output logic [WIDTH-1:0]           rowData,
    output logic [$clog2(ROWS)-1:0]    level,
    output logic [$clog2(WIDTH+1)-1:0] blocksLeft,
    output logic                       gameOver,
    output logic                       gameWin
);
    localparam int LW = $clog2(ROWS);
    localparam int CW = $clog2(WIDTH+1);

    logic [WIDTH-1:0] startPat;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : gStartPat
            assign startPat[gi] = startBit(gi, WIDTH, START_LEN);
        end
    endgenerate

    logic [2:0]       stateReg, stateNext;
    logic [LW-1:0]    levelReg, levelNext;
    logic [WIDTH-1:0] patternReg, patternNext;
    logic [WIDTH-1:0] capReg, capNext;
    logic [WIDTH-1:0] ovReg, ovNext;
    logic             startPrevReg, stopPrevReg;
    logic             startEdge, stopEdge;
    logic             memClr, memWe;
    logic [WIDTH-1:0] belowRow;

    assign startEdge = startBtn & ~startPrevReg;
    assign stopEdge  = stopBtn & ~stopPrevReg;

    stack_row_mem #(
        .WIDTH (WIDTH),
        .ROWS  (ROWS)
    ) uRowMem (
        .clk     (clk),
        .rst     (rst),
        .clr     (memClr),
        .wrEn    (memWe),
        .wrAddr  (levelReg),
        .wrData  (ovReg),
        .rdAddrA (rowSel),
        .rdDataA (rowData),
        .rdAddrB (levelReg - LW'(1)),
        .rdDataB (belowRow)
    );

    always_comb begin
        stateNext   = stateReg;
        levelNext   = levelReg;
        patternNext = patternReg;
        capNext     = capReg;
        ovNext      = ovReg;
        memClr      = 1'b0;
        memWe       = 1'b0;
        case (stateReg)
            ST_IDLE, ST_LOSE, ST_WIN: begin
                if (startEdge) begin
                    memClr      = 1'b1;
                    levelNext   = '0;
                    patternNext = startPat;
                    stateNext   = ST_LOAD;
                end
            end
            ST_LOAD: stateNext = ST_RUN;
            ST_RUN: begin
                if (stopEdge) begin
                    capNext   = curRow;
                    stateNext = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // Row 0 sits on the floor, so it keeps the whole capture.
                ovNext    = (levelReg == '0) ? capReg : (capReg & belowRow);
                stateNext = (ovNext == '0) ? ST_LOSE : ST_COMMIT;
            end
            ST_COMMIT: begin
                memWe = 1'b1;
                if (levelReg == LW'(ROWS-1)) begin
                    stateNext = ST_WIN;
                end else begin
                    levelNext   = levelReg + LW'(1);
                    patternNext = ovReg;
                    stateNext   = ST_LOAD;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg     <= ST_IDLE;
            levelReg     <= '0;
            patternReg   <= startPat;
            capReg       <= '0;
            ovReg        <= '0;
            // Held buttons at reset must not register as fresh presses.
            startPrevReg <= 1'b1;
            stopPrevReg  <= 1'b1;
        end else begin
            stateReg     <= stateNext;
            levelReg     <= levelNext;
            patternReg   <= patternNext;
            capReg       <= capNext;
            ovReg        <= ovNext;
            startPrevReg <= startBtn;
            stopPrevReg  <= stopBtn;
        end
    end

    always_comb begin
        blocksLeft = '0;
        for (int i = 0; i < WIDTH; i++) begin
            blocksLeft = blocksLeft + CW'(patternReg[i]);
        end
    end

    assign shiftLoad    = (stateReg == ST_LOAD);
    assign shiftRun     = (stateReg == ST_RUN);
    assign gameOver     = (stateReg == ST_LOSE);
    assign gameWin      = (stateReg == ST_WIN);
    assign shiftPattern = patternReg;
    assign level        = levelReg;

endmodule

// File: tb/tb_stack_game_ctrl.sv
// Directed bench for stack_game_ctrl: a per-cycle vector table for the basic
// game flow and loss, plus hand sequences for a full win and button/reset corners.
module tb_stack_game_ctrl;
    import stack_game_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       startBtn;
    logic       stopBtn;
    logic [7:0] curRow;
    logic       shiftLoad;
    logic [7:0] shiftPattern;
    logic       shiftRun;
    logic [2:0] rowSel;
    logic [7:0] rowData;
    logic [2:0] level;
    logic [3:0] blocksLeft;
    logic       gameOver;
    logic       gameWin;

    int nChecks = 0;
    int nFails  = 0;

    stack_game_ctrl #(
        .WIDTH     (8),
        .ROWS      (8),
        .START_LEN (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .startBtn     (startBtn),
        .stopBtn      (stopBtn),
        .curRow       (curRow),
        .shiftLoad    (shiftLoad),
        .shiftPattern (shiftPattern),
        .shiftRun     (shiftRun),
        .rowSel       (rowSel),
        .rowData      (rowData),
        .level        (level),
        .blocksLeft   (blocksLeft),
        .gameOver     (gameOver),
        .gameWin      (gameWin)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, start, stop;
        logic [7:0] cur;
        logic [2:0] sel;
        logic       load, run;
        logic [7:0] pat;
        logic [2:0] lvl;
        logic [3:0] blk;
        logic       over, win;
        logic [7:0] rdata;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic r, input logic st, input logic sp,
                                input logic [7:0] cur, input logic [2:0] sel,
                                input logic ld, input logic rn, input logic [7:0] pat,
                                input logic [2:0] lvl, input logic [3:0] blk,
                                input logic ov, input logic wn, input logic [7:0] rd);
        vec_t v;
        v.rst = r; v.start = st; v.stop = sp; v.cur = cur; v.sel = sel;
        v.load = ld; v.run = rn; v.pat = pat; v.lvl = lvl; v.blk = blk;
        v.over = ov; v.win = wn; v.rdata = rd;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic waitRun(input string name);
        int n = 0;
        while (!shiftRun && n < 20) begin
            tick();
            n++;
        end
        chk(name, 32'(shiftRun), 32'd1);
    endtask

    initial begin
        logic [7:0] gotPack;
        logic [7:0] expPack;

        //            rst st sp cur    sel  ld rn pat    lvl blk ov wn rdata
        vecs[0]  = mk(1, 0, 0, 8'h00, 3'd0, 0, 0, 8'hE0, 3'd0, 4'd3, 0, 0, 8'h00);
        vecs[1]  = mk(0, 0, 0, 8'h00, 3'd0, 0, 0, 8'hE0, 3'd0, 4'd3, 0, 0, 8'h00);
        vecs[2]  = mk(0, 1, 0, 8'h00, 3'd0, 1, 0, 8'hE0, 3'd0, 4'd3, 0, 0, 8'h00);
        vecs[3]  = mk(0, 1, 0, 8'h00, 3'd0, 0, 1, 8'hE0, 3'd0, 4'd3, 0, 0, 8'h00);
        vecs[4]  = mk(0, 0, 1, 8'h38, 3'd0, 0, 0, 8'hE0, 3'd0, 4'd3, 0, 0, 8'h00);
        vecs[5]  = mk(0, 0, 1, 8'h00, 3'd0, 0, 0, 8'hE0, 3'd0, 4'd3, 0, 0, 8'h00);
        vecs[6]  = mk(0, 0, 0, 8'h00, 3'd0, 1, 0, 8'h38, 3'd1, 4'd3, 0, 0, 8'h38);
        vecs[7]  = mk(0, 0, 0, 8'h00, 3'd0, 0, 1, 8'h38, 3'd1, 4'd3, 0, 0, 8'h38);
        vecs[8]  = mk(0, 0, 1, 8'h1C, 3'd1, 0, 0, 8'h38, 3'd1, 4'd3, 0, 0, 8'h00);
        vecs[9]  = mk(0, 0, 0, 8'h00, 3'd1, 0, 0, 8'h38, 3'd1, 4'd3, 0, 0, 8'h00);
        vecs[10] = mk(0, 0, 0, 8'h00, 3'd1, 1, 0, 8'h18, 3'd2, 4'd2, 0, 0, 8'h18);
        vecs[11] = mk(0, 0, 0, 8'h00, 3'd1, 0, 1, 8'h18, 3'd2, 4'd2, 0, 0, 8'h18);
        vecs[12] = mk(0, 0, 1, 8'hC0, 3'd1, 0, 0, 8'h18, 3'd2, 4'd2, 0, 0, 8'h18);
        vecs[13] = mk(0, 0, 0, 8'h00, 3'd1, 0, 0, 8'h18, 3'd2, 4'd2, 1, 0, 8'h18);
        vecs[14] = mk(0, 0, 1, 8'h18, 3'd2, 0, 0, 8'h18, 3'd2, 4'd2, 1, 0, 8'h00);
        vecs[15] = mk(0, 1, 0, 8'h00, 3'd0, 1, 0, 8'hE0, 3'd0, 4'd3, 0, 0, 8'h00);
        vecs[16] = mk(0, 0, 0, 8'h00, 3'd0, 0, 1, 8'hE0, 3'd0, 4'd3, 0, 0, 8'h00);
        vecs[17] = mk(0, 0, 1, 8'h38, 3'd0, 0, 0, 8'hE0, 3'd0, 4'd3, 0, 0, 8'h00);
        vecs[18] = mk(0, 0, 0, 8'h00, 3'd0, 0, 0, 8'hE0, 3'd0, 4'd3, 0, 0, 8'h00);
        vecs[19] = mk(0, 0, 0, 8'h00, 3'd0, 1, 0, 8'h38, 3'd1, 4'd3, 0, 0, 8'h38);
        vecs[20] = mk(0, 0, 0, 8'h00, 3'd0, 0, 1, 8'h38, 3'd1, 4'd3, 0, 0, 8'h38);
        vecs[21] = mk(0, 0, 1, 8'hC0, 3'd0, 0, 0, 8'h38, 3'd1, 4'd3, 0, 0, 8'h38);
        vecs[22] = mk(0, 0, 0, 8'h00, 3'd1, 0, 0, 8'h38, 3'd1, 4'd3, 1, 0, 8'h00);
        vecs[23] = mk(0, 0, 0, 8'h00, 3'd0, 0, 0, 8'h38, 3'd1, 4'd3, 1, 0, 8'h38);

        rst = 1'b1; startBtn = 1'b0; stopBtn = 1'b0; curRow = 8'h00; rowSel = 3'd0;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            rst = vecs[i].rst; startBtn = vecs[i].start; stopBtn = vecs[i].stop;
            curRow = vecs[i].cur; rowSel = vecs[i].sel;
            tick();
            nChecks++;
            if (shiftLoad !== vecs[i].load || shiftRun !== vecs[i].run ||
                shiftPattern !== vecs[i].pat || level !== vecs[i].lvl ||
                blocksLeft !== vecs[i].blk || gameOver !== vecs[i].over ||
                gameWin !== vecs[i].win || rowData !== vecs[i].rdata) begin
                nFails++;
                $display("FAIL vec%0d: got ld=%b run=%b pat=%h lvl=%0d blk=%0d over=%b win=%b row=%h, expected ld=%b run=%b pat=%h lvl=%0d blk=%0d over=%b win=%b row=%h",
                         i, shiftLoad, shiftRun, shiftPattern, level, blocksLeft, gameOver, gameWin, rowData,
                         vecs[i].load, vecs[i].run, vecs[i].pat, vecs[i].lvl, vecs[i].blk,
                         vecs[i].over, vecs[i].win, vecs[i].rdata);
            end else begin
                $display("vec%0d ok: ld=%b run=%b pat=%h lvl=%0d blk=%0d over=%b win=%b row=%h",
                         i, shiftLoad, shiftRun, shiftPattern, level, blocksLeft, gameOver, gameWin, rowData);
            end
        end

        // Full game with perfectly aligned stops: eight commits lead to WIN.
        rst = 1'b1; startBtn = 1'b0; stopBtn = 1'b0; curRow = 8'h00;
        tick();
        rst = 1'b0; tick();
        startBtn = 1'b1; tick();
        chk("win_load0", 32'(shiftLoad), 32'd1);
        chk("win_pat0", 32'(shiftPattern), 32'(DEF_START_PATTERN));
        startBtn = 1'b0;
        for (int r = 0; r < 8; r++) begin
            waitRun($sformatf("win_run%0d", r));
            chk($sformatf("win_lvl%0d", r), 32'(level), 32'(r));
            curRow = 8'hE0; stopBtn = 1'b1; tick();
            stopBtn = 1'b0; curRow = 8'h00; tick();
            tick();
            $display("row %0d committed: level=%0d win=%b", r, level, gameWin);
        end
        chk("win_flag", 32'(gameWin), 32'd1);
        chk("win_level", 32'(level), 32'd7);
        chk("win_over", 32'(gameOver), 32'd0);
        for (int k = 0; k < 2; k++) begin
            stopBtn = 1'b1; curRow = 8'h01; tick();
            stopBtn = 1'b0; tick();
        end
        chk("win_hold", 32'(gameWin), 32'd1);
        chk("win_hold_lvl", 32'(level), 32'd7);
        chk("win_hold_run", 32'(shiftRun), 32'd0);
        gotPack = '0;
        expPack = 8'hFF;
        for (int r = 0; r < 8; r++) begin
            rowSel = 3'(r); #1;
            gotPack[r] = (rowData == 8'hE0);
        end
        chk("win_stack", 32'(gotPack), 32'(expPack));

        // Stop held through reset and into the game: no phantom capture.
        stopBtn = 1'b1; rst = 1'b1; tick();
        rst = 1'b0; tick();
        startBtn = 1'b1; tick();
        chk("held_load", 32'(shiftLoad), 32'd1);
        startBtn = 1'b0; curRow = 8'hE0;
        tick(); tick(); tick();
        chk("held_run", 32'(shiftRun), 32'd1);
        chk("held_lvl", 32'(level), 32'd0);
        // Release, press in RUN, then press again while LOAD is active.
        stopBtn = 1'b0; tick();
        stopBtn = 1'b1; tick();
        stopBtn = 1'b0; tick();
        tick();
        chk("ld_state", 32'(shiftLoad), 32'd1);
        chk("ld_lvl", 32'(level), 32'd1);
        stopBtn = 1'b1; curRow = 8'h00; tick();
        chk("ld_ignored", 32'(shiftRun), 32'd1);
        tick(); tick();
        chk("ld_still_run", 32'(shiftRun), 32'd1);
        chk("ld_no_over", 32'(gameOver), 32'd0);
        // Reset mid-RUN wipes the stack and parks in IDLE.
        stopBtn = 1'b0; rowSel = 3'd0; rst = 1'b1; tick();
        chk("mid_rst_run", 32'(shiftRun), 32'd0);
        chk("mid_rst_lvl", 32'(level), 32'd0);
        chk("mid_rst_row", 32'(rowData), 32'd0);
        chk("mid_rst_pat", 32'(shiftPattern), 32'hE0);
        rst = 1'b0; stopBtn = 1'b1; tick();
        tick(); tick();
        chk("idle_no_load", 32'({shiftLoad, shiftRun, gameOver, gameWin}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
